// File: rtl/eth_helper_pkg.sv
// Shared types and constants for the Ethernet helper outbound stream path.
package eth_helper_pkg;

    typedef enum logic [0:0] {
        ARB   = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

    localparam int N_CH  = 5;
    localparam int CH_AW = 0;
    localparam int CH_W  = 1;
    localparam int CH_B  = 2;
    localparam int CH_AR = 3;
    localparam int CH_R  = 4;

    localparam int SKID_DEPTH = 2;

endpackage

// File: rtl/eth_stream_arbiter_if.sv
// Tap-side request bundle plus the shared outbound AXI-Stream of the arbiter.
interface eth_stream_arbiter_if
    import eth_helper_pkg::*;
#(
    parameter int N_REQ      = N_CH,
    parameter int DATA_WIDTH = 128,
    parameter int IDX_W      = $clog2(N_REQ)
);

    logic [N_REQ-1:0]            req_valid;
    logic [N_REQ-1:0]            req_in_progress;
    logic [N_REQ-1:0]            req_last;
    logic [N_REQ*DATA_WIDTH-1:0] req_data;
    logic [N_REQ-1:0]            req_ready;

    logic [DATA_WIDTH-1:0]       m_axis_tdata;
    logic                        m_axis_tvalid;
    logic                        m_axis_tlast;
    logic [IDX_W-1:0]            m_axis_tdest;
    logic                        m_axis_tready;

    logic                        busy;

    // The arbiter consumes tap requests and sources the outbound stream.
    modport slave (
        input  req_valid, req_in_progress, req_last, req_data, m_axis_tready,
        output req_ready, m_axis_tdata, m_axis_tvalid, m_axis_tlast, m_axis_tdest, busy
    );

    modport master (
        output req_valid, req_in_progress, req_last, req_data, m_axis_tready,
        input  req_ready, m_axis_tdata, m_axis_tvalid, m_axis_tlast, m_axis_tdest, busy
    );

endinterface

// File: rtl/stream_skid_buffer.sv
// Two-entry FIFO that decouples downstream ready from the upstream ready path.
module stream_skid_buffer
    import eth_helper_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             push_valid,
    output logic             push_ready,
    input  logic [WIDTH-1:0] push_data,
    output logic             pop_valid,
    input  logic             pop_ready,
    output logic [WIDTH-1:0] pop_data
);

    logic [WIDTH-1:0] mem [SKID_DEPTH];
    logic             wr_ptr;
    logic             rd_ptr;
    logic [1:0]       count;
    logic [1:0]       count_next;
    logic             not_full;
    logic             push;
    logic             pop;

    assign push       = push_valid && push_ready;
    assign pop        = pop_valid && pop_ready;
    assign count_next = count + 2'(push) - 2'(pop);

    // push_ready comes from a flop so downstream tready never reaches the taps combinationally.
    assign push_ready = not_full;
    assign pop_valid  = (count != 2'd0);
    assign pop_data   = mem[rd_ptr];

    // NOTE: storage is reset too, so the head (and hence tdata) reads zero out of reset.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < SKID_DEPTH; i++) mem[i] <= '0;
            wr_ptr   <= 1'b0;
            rd_ptr   <= 1'b0;
            count    <= 2'd0;
            not_full <= 1'b1;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) rd_ptr <= ~rd_ptr;
            count    <= count_next;
            not_full <= (count_next < 2'(SKID_DEPTH));
        end
    end

endmodule

// File: rtl/eth_stream_arbiter.sv
// Round-robin, frame-locked arbiter sharing one outbound AXI-Stream among the AW/W/B/AR/R taps.
module eth_stream_arbiter
    import eth_helper_pkg::*;
#(
    parameter int N_REQ      = N_CH,
    parameter int DATA_WIDTH = 128,
    parameter int IDX_W      = $clog2(N_REQ)
) (
    input  logic                clk,
    input  logic                resetn,
    eth_stream_arbiter_if.slave bus
);

    localparam logic [0:0] ST_ARB   = ARB;
    localparam logic [0:0] ST_GRANT = GRANT;

    typedef struct packed {
        logic [IDX_W-1:0]      dest;
        logic                  last;
        logic [DATA_WIDTH-1:0] data;
    } beat_t;

    localparam int BEAT_W = $bits(beat_t);

    logic [0:0]            state;
    logic [IDX_W-1:0]      rr_ptr;
    logic [IDX_W-1:0]      grant_idx;
    logic [IDX_W-1:0]      pick_idx;
    logic [IDX_W-1:0]      rr_next;
    logic                  pick_found;
    logic [DATA_WIDTH-1:0] req_slice [N_REQ];
    logic                  g_valid;
    logic                  g_in_progress;
    logic                  g_last;
    logic                  push_valid;
    logic                  push_ready;
    logic                  push_fire;
    logic                  pop_valid;
    beat_t                 push_beat;
    beat_t                 pop_beat;

    always_comb begin
        for (int i = 0; i < N_REQ; i++) begin
            req_slice[i] = bus.req_data[i*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    // First valid requester at or after rr_ptr; the wrap is at N_REQ, not at 2**IDX_W.
    always_comb begin
        int unsigned cand;
        // NOTE: every output of this block gets a default first so no latch is inferred.
        pick_found = 1'b0;
        pick_idx   = '0;
        cand       = 0;
        for (int k = 0; k < N_REQ; k++) begin
            cand = 32'(rr_ptr) + 32'(k);
            if (cand >= N_REQ) cand = cand - N_REQ;
            if (!pick_found && bus.req_valid[cand]) begin
                pick_found = 1'b1;
                pick_idx   = IDX_W'(cand);
            end
        end
    end

    assign g_valid       = bus.req_valid[grant_idx];
    assign g_in_progress = bus.req_in_progress[grant_idx];
    assign g_last        = bus.req_last[grant_idx];
    assign push_valid    = (state == ST_GRANT) && g_valid;
    assign push_fire     = push_valid && push_ready;
    assign rr_next       = (grant_idx == IDX_W'(N_REQ - 1)) ? '0 : grant_idx + IDX_W'(1);

    // Metadata beats (in_progress low) never carry tlast, whatever the tap drives on last.
    assign push_beat = '{dest: grant_idx,
                         last: g_last && g_in_progress,
                         data: req_slice[grant_idx]};

    always_comb begin
        bus.req_ready = '0;
        if (state == ST_GRANT) bus.req_ready[grant_idx] = push_ready;
    end

    // NOTE: all state here is updated with non-blocking assignments.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state     <= ST_ARB;
            rr_ptr    <= '0;
            grant_idx <= '0;
        end else begin
            case (state)
                ST_ARB: begin
                    if (pick_found) begin
                        grant_idx <= pick_idx;
                        state     <= ST_GRANT;
                    end
                end
                ST_GRANT: begin
                    // A tap stalled mid-frame keeps the grant; only a tap that withdrew before metadata loses it.
                    if (push_fire && g_last && g_in_progress) begin
                        state  <= ST_ARB;
                        rr_ptr <= rr_next;
                    end else if (!g_valid && !g_in_progress) begin
                        state <= ST_ARB;
                    end
                end
            endcase
        end
    end

    stream_skid_buffer #(
        .WIDTH (BEAT_W)
    ) u_skid (
        .clk        (clk),
        .resetn     (resetn),
        .push_valid (push_valid),
        .push_ready (push_ready),
        .push_data  (push_beat),
        .pop_valid  (pop_valid),
        .pop_ready  (bus.m_axis_tready),
        .pop_data   (pop_beat)
    );

    assign bus.m_axis_tvalid = pop_valid;
    assign bus.m_axis_tdata  = pop_beat.data;
    assign bus.m_axis_tlast  = pop_beat.last;
    assign bus.m_axis_tdest  = pop_beat.dest;
    assign bus.busy          = (state == ST_GRANT) || pop_valid;

endmodule

// File: tb/tb_eth_stream_arbiter.sv
// Scoreboard bench for eth_stream_arbiter: tap models push expected beats, a stream monitor pops and compares.
`timescale 1ns/1ps
module tb_eth_stream_arbiter;
    import eth_helper_pkg::*;

    localparam int N_REQ = N_CH;
    localparam int DW    = 128;
    localparam int IW    = 3;

    typedef struct packed {
        logic [IW-1:0] dest;
        logic          last;
        logic [DW-1:0] data;
    } beat_t;

    typedef struct {
        int tap;
        int n_data;
        int exp_rr;
    } vec_t;

    logic clk    = 1'b0;
    logic resetn = 1'b0;
    int   cyc    = 0;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   beats_out = 0;

    beat_t sb[$];
    int    frame_order[$];
    logic  stall_prev = 1'b0;
    beat_t held;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    eth_stream_arbiter_if #(.N_REQ(N_REQ), .DATA_WIDTH(DW), .IDX_W(IW)) bus ();

    eth_stream_arbiter #(.N_REQ(N_REQ), .DATA_WIDTH(DW), .IDX_W(IW)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [159:0] outs_vec();
        return {bus.m_axis_tvalid, bus.m_axis_tlast, bus.m_axis_tdest, bus.m_axis_tdata,
                bus.req_ready, bus.busy};
    endfunction

    // Stream-side monitor: pops the scoreboard on every transfer and checks hold-while-stalled.
    always @(negedge clk) begin
        beat_t cur;
        cur = '{dest: bus.m_axis_tdest, last: bus.m_axis_tlast, data: bus.m_axis_tdata};
        if (!resetn) begin
            stall_prev = 1'b0;
        end else begin
            check("req_ready_onehot0", 160'($onehot0(bus.req_ready)), 160'd1);
            if (stall_prev) check("hold_while_stalled", {bus.m_axis_tvalid, cur}, {1'b1, held});
            if (bus.m_axis_tvalid && bus.m_axis_tready) begin
                beats_out++;
                check("beat_expected", 160'(sb.size() != 0), 160'd1);
                if (sb.size() != 0) check("beat", cur, sb.pop_front());
                if (cur.last) frame_order.push_back(int'(cur.dest));
            end
            stall_prev = bus.m_axis_tvalid && !bus.m_axis_tready;
            held       = cur;
        end
    end

    // One tap's frame: a metadata beat, then n_data beats with last on the final one.
    task automatic send_frame(input int tap, input int n_data, output int first_acc, output int last_acc);
        logic [DW-1:0] d;
        logic          acc;
        first_acc = -1;
        last_acc  = -1;
        for (int b = 0; b <= n_data; b++) begin
            d = (b == 0) ? ((DW'(tap) << (DW - 4)) | DW'(5))
                         : {$urandom, $urandom, $urandom, $urandom};
            bus.req_valid[tap]       = 1'b1;
            bus.req_in_progress[tap] = (b != 0);
            bus.req_last[tap]        = (b == 0) || (b == n_data);
            bus.req_data[tap*DW +: DW] = d;
            acc = 1'b0;
            for (int t = 0; t < 500 && !acc; t++) begin
                @(negedge clk);
                if (bus.req_ready[tap]) begin
                    acc = 1'b1;
                    sb.push_back('{dest: IW'(tap), last: (b != 0) && (b == n_data), data: d});
                    if (b == 0) first_acc = cyc;
                    last_acc = cyc;
                end
                @(posedge clk);
                #1;
            end
            check($sformatf("accept_tap%0d_beat%0d", tap, b), 160'(acc), 160'd1);
            if (!acc) break;
        end
        bus.req_valid[tap]       = 1'b0;
        bus.req_in_progress[tap] = 1'b0;
        bus.req_last[tap]        = 1'b0;
    endtask

    task automatic wait_idle();
        logic idle;
        idle = 1'b0;
        for (int t = 0; t < 200 && !idle; t++) begin
            @(negedge clk);
            idle = !bus.busy && (sb.size() == 0);
        end
        check("drain_idle", 160'(idle), 160'd1);
        @(posedge clk);
        #1;
    endtask

    function automatic int order_code();
        int code = 0;
        foreach (frame_order[i]) code = code * 16 + frame_order[i];
        return code;
    endfunction

    task automatic start_test();
        frame_order.delete();
        beats_out = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2 resetn = 1'b0;
        @(negedge clk);
        #2 resetn = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[6];
        int   f0, l0, f1, l1, rise, seen;

        tbl = '{'{CH_AW, 2, 1}, '{CH_B, 1, 3}, '{CH_W, 3, 2},
                '{CH_R, 1, 0}, '{CH_AR, 2, 4}, '{CH_B, 2, 3}};

        bus.req_valid       = '0;
        bus.req_in_progress = '0;
        bus.req_last        = '0;
        bus.req_data        = '0;
        bus.m_axis_tready   = 1'b1;

        repeat (3) @(posedge clk);
        #1 check("outputs_in_reset", outs_vec(), '0);
        @(negedge clk) resetn = 1'b1;
        @(negedge clk) check("outputs_after_release", outs_vec(), '0);
        @(posedge clk);
        #1;

        // Single R frame: metadata + 3 data beats, latency from req_valid to tvalid.
        start_test();
        rise = cyc;
        seen = -1;
        fork
            send_frame(CH_R, 3, f0, l0);
            begin
                for (int t = 0; t < 20 && seen < 0; t++) begin
                    @(negedge clk);
                    if (bus.m_axis_tvalid) seen = cyc;
                end
            end
        join
        check("first_tvalid_latency", 160'(seen - rise), 160'd2);
        wait_idle();
        check("r_frame_beats", 160'(beats_out), 160'd4);
        check("r_frame_order", 160'(order_code()), 160'h4);
        check("r_rr_ptr", 160'(dut.rr_ptr), 160'd0);

        // Table of lone frames; rr_ptr must land on tap+1 mod N_REQ.
        for (int i = 0; i < 6; i++) begin
            start_test();
            send_frame(tbl[i].tap, tbl[i].n_data, f0, l0);
            wait_idle();
            check($sformatf("tbl%0d_beats", i), 160'(beats_out), 160'(tbl[i].n_data + 1));
            check($sformatf("tbl%0d_order", i), 160'(order_code()), 160'(tbl[i].tap));
            check($sformatf("tbl%0d_rr_ptr", i), 160'(dut.rr_ptr), 160'(tbl[i].exp_rr));
        end

        // AR granted then withdraws before metadata; R must be served, rr_ptr stays 3 meanwhile.
        start_test();
        fork
            send_frame(CH_R, 1, f0, l0);
            begin
                bus.req_valid[CH_AR] = 1'b1;
                bus.req_data[CH_AR*DW +: DW] = 128'h3;
                @(negedge clk) check("withdraw_arb_ready", 160'(bus.req_ready), 160'd0);
                @(posedge clk);
                #1 bus.req_valid[CH_AR] = 1'b0;
                @(negedge clk) check("withdraw_granted_ar", 160'(bus.req_ready), 160'b01000);
                @(negedge clk) check("withdraw_rr_ptr", 160'(dut.rr_ptr), 160'd3);
                check("withdraw_back_to_arb", 160'(bus.req_ready), 160'd0);
            end
        join
        wait_idle();
        check("withdraw_order", 160'(order_code()), 160'h4);
        check("withdraw_rr_after", 160'(dut.rr_ptr), 160'd0);

        // AW, B, R all valid from reset; then AW vs AR after the wrap.
        do_reset();
        start_test();
        fork
            send_frame(CH_AW, 1, f0, l0);
            send_frame(CH_B, 1, f1, l1);
            send_frame(CH_R, 1, rise, seen);
        join
        wait_idle();
        check("rr_order_0_2_4", 160'(order_code()), 160'h024);
        start_test();
        fork
            send_frame(CH_AW, 1, f0, l0);
            send_frame(CH_AR, 1, f1, l1);
        join
        wait_idle();
        check("wrap_aw_first", 160'(order_code()), 160'h03);

        // Back-to-back W then B: exactly one idle cycle between frames.
        start_test();
        fork
            send_frame(CH_W, 2, f0, l0);
            send_frame(CH_B, 2, f1, l1);
        join
        wait_idle();
        check("b2b_gap", 160'(f1 - l0), 160'd2);
        check("b2b_order", 160'(order_code()), 160'h12);

        // W frame with tready low for 5 cycles mid-frame.
        start_test();
        fork
            send_frame(CH_W, 6, f0, l0);
            begin
                repeat (3) @(posedge clk);
                #1 bus.m_axis_tready = 1'b0;
                for (int k = 0; k < 5; k++) begin
                    @(negedge clk);
                    if (k >= 2) begin
                        check("stall_ready_low", 160'(bus.req_ready), 160'd0);
                        check("stall_skid_full", 160'(dut.u_skid.count), 160'd2);
                    end
                    @(posedge clk);
                    #1;
                end
                bus.m_axis_tready = 1'b1;
            end
        join
        wait_idle();
        check("stall_beats", 160'(beats_out), 160'd7);
        check("stall_order", 160'(order_code()), 160'h1);

        // Reset pulse while the skid holds two beats; next frames start from rr_ptr=0.
        start_test();
        bus.m_axis_tready = 1'b0;
        bus.req_valid[CH_AW] = 1'b1;
        bus.req_data[CH_AW*DW +: DW] = 128'hdead_beef;
        repeat (5) @(posedge clk);
        @(negedge clk);
        check("pre_reset_full", {bus.m_axis_tvalid, bus.req_ready, dut.u_skid.count}, {1'b1, 5'd0, 2'd2});
        #2 resetn = 1'b0;
        bus.req_valid = '0;
        #1 check("async_reset_outputs", outs_vec(), '0);
        @(negedge clk);
        #2 resetn = 1'b1;
        bus.m_axis_tready = 1'b1;
        @(negedge clk);
        check("post_reset_outputs", outs_vec(), '0);
        check("post_reset_rr_ptr", 160'(dut.rr_ptr), 160'd0);
        @(posedge clk);
        #1;
        fork
            send_frame(CH_AR, 1, f0, l0);
            send_frame(CH_W, 1, f1, l1);
        join
        wait_idle();
        check("post_reset_order", 160'(order_code()), 160'h13);
        check("scoreboard_empty", 160'(sb.size()), 160'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
